// File: rtl/fifo_wr_packer.sv
// Write-side packer for the synchronous FIFO: gathers RATIO narrow beats into one
// FIFO-wide word (little-endian lanes) and drives winc/wdata behind a one-word hold slot.
module fifo_wr_packer #(
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned RATIO     = 4,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                          wclk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [IN_WIDTH-1:0]           in_data,
  input  logic                          in_last,
  output logic                          in_ready,
  input  logic                          flush,
  input  logic                          wfull,
  output logic                          winc,
  output logic [IN_WIDTH*RATIO-1:0]     wdata,
  output logic [$clog2(RATIO):0]        lanes,
  output logic [CNT_WIDTH-1:0]          word_count
);

  localparam int unsigned OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int unsigned LANE_W    = $clog2(RATIO);

  logic [OUT_WIDTH-1:0] asm_q, asm_d;
  logic [LANE_W-1:0]    lane_q, lane_d;
  logic [OUT_WIDTH-1:0] hold_q, hold_d;
  logic                 hold_valid_q, hold_valid_d;
  logic                 flush_pend_q, flush_pend_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic                 slot_free, acc, take, flush_req, has_data;
  logic                 close_beat, close_flush;
  logic [OUT_WIDTH-1:0] merged;

  // Hold slot is usable when empty or being drained by the FIFO this cycle
  assign take      = hold_valid_q & ~wfull;
  assign slot_free = ~hold_valid_q | ~wfull;
  assign acc       = in_valid & slot_free;
  assign flush_req = flush | flush_pend_q;
  assign has_data  = (lane_q != '0);

  // Upper lanes of asm_q are always zero, so the merged word is already padded
  always_comb begin
    merged = asm_q;
    for (int k = 0; k < int'(RATIO); k++) begin
      if (LANE_W'(k) == lane_q) merged[k*IN_WIDTH +: IN_WIDTH] = in_data;
    end
  end

  assign close_beat  = acc & ((lane_q == LANE_W'(RATIO - 1)) | in_last | flush_req);
  assign close_flush = ~acc & flush_req & has_data & slot_free;

  always_comb begin
    asm_d        = asm_q;
    lane_d       = lane_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q & ~take;
    flush_pend_d = 1'b0;
    cnt_d        = cnt_q + CNT_WIDTH'(take);
    if (close_beat) begin
      hold_d       = merged;
      hold_valid_d = 1'b1;
      asm_d        = '0;
      lane_d       = '0;
    end else if (acc) begin
      asm_d  = merged;
      lane_d = lane_q + LANE_W'(1);
    end else if (close_flush) begin
      hold_d       = asm_q;
      hold_valid_d = 1'b1;
      asm_d        = '0;
      lane_d       = '0;
    end else if (flush_req && has_data) begin
      // Hold slot blocked: remember the flush until it can be honoured
      flush_pend_d = 1'b1;
    end
  end

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q        <= '0;
      lane_q       <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      flush_pend_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      asm_q        <= asm_d;
      lane_q       <= lane_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      flush_pend_q <= flush_pend_d;
      cnt_q        <= cnt_d;
    end
  end

  assign winc       = take;
  assign in_ready   = slot_free;
  assign wdata      = hold_q;
  assign lanes      = {1'b0, lane_q};
  assign word_count = cnt_q;

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Scoreboard bench for fifo_wr_packer: a small packing model pushes expected words,
// a negedge monitor pops and compares them on every FIFO write.
module tb_fifo_wr_packer;

  localparam int unsigned IW = 8;
  localparam int unsigned R  = 4;
  localparam int unsigned CW = 16;
  localparam int unsigned OW = IW * R;

  logic          wclk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_last, flush, wfull;
  logic [IW-1:0] in_data;
  logic          in_ready, winc;
  logic [OW-1:0] wdata;
  logic [2:0]    lanes;
  logic [CW-1:0] word_count;

  always #5 wclk = ~wclk;

  fifo_wr_packer #(.IN_WIDTH(IW), .RATIO(R), .CNT_WIDTH(CW)) dut (
    .wclk(wclk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .flush(flush), .wfull(wfull),
    .winc(winc), .wdata(wdata), .lanes(lanes), .word_count(word_count)
  );

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [OW-1:0] sb[$];
  logic [OW-1:0] mdl_word;
  int            mdl_lane;
  logic [CW-1:0] exp_wc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mdl_close();
    if (mdl_lane > 0) begin
      sb.push_back(mdl_word);
      mdl_word = '0;
      mdl_lane = 0;
      exp_wc   = exp_wc + CW'(1);
    end
  endtask

  task automatic send_beat(input logic [IW-1:0] d, input logic last, input logic fl);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = last; flush = fl;
    @(negedge wclk);
    while (!in_ready && n < 50) begin
      @(negedge wclk);
      n++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    mdl_word[mdl_lane*IW +: IW] = d;
    mdl_lane++;
    if (mdl_lane == int'(R) || last || fl) mdl_close();
    @(posedge wclk); #1;
    in_valid = 1'b0; in_last = 1'b0; flush = 1'b0; in_data = '0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge wclk);
    mdl_close();
    @(posedge wclk); #1;
    flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge wclk);
    #1;
  endtask

  // Every FIFO write must match the oldest word the model produced
  always @(negedge wclk) begin
    if (rst_n && winc) begin
      if (sb.size() == 0) check("winc_without_word", 32'(sb.size() > 0), 32'd1);
      else check("wdata", wdata, sb.pop_front());
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; flush = 1'b0; wfull = 1'b0;
    mdl_word = '0; mdl_lane = 0; exp_wc = '0;
    #12;
    check("rst_winc", 32'(winc), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_lanes", 32'(lanes), 32'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_count", 32'(word_count), 32'd0);
    @(posedge wclk); #1 rst_n = 1'b1;
    idle(1);

    // Full word with one-cycle latency
    send_beat(8'h11, 1'b0, 1'b0);
    send_beat(8'h22, 1'b0, 1'b0);
    send_beat(8'h33, 1'b0, 1'b0);
    check("full_lanes3", 32'(lanes), 32'd3);
    send_beat(8'h44, 1'b0, 1'b0);
    check("full_lanes0", 32'(lanes), 32'd0);
    @(negedge wclk);
    check("full_latency", 32'(winc), 32'd1);
    check("full_wdata", wdata, 32'h44332211);
    idle(2);
    check("full_count", 32'(word_count), 32'(exp_wc));

    // in_last pads the remainder
    send_beat(8'hAA, 1'b0, 1'b0);
    send_beat(8'hBB, 1'b1, 1'b0);
    idle(3);
    check("last_count", 32'(word_count), 32'(exp_wc));

    // Flush of one lane, then flush with nothing held
    send_beat(8'h5C, 1'b0, 1'b0);
    check("flush_lanes1", 32'(lanes), 32'd1);
    do_flush();
    idle(3);
    do_flush();
    idle(3);
    check("flush_count", 32'(word_count), 32'(exp_wc));

    // Beat and flush in the same cycle
    send_beat(8'h01, 1'b0, 1'b0);
    send_beat(8'h02, 1'b0, 1'b0);
    send_beat(8'h77, 1'b0, 1'b1);
    idle(3);
    check("simul_count", 32'(word_count), 32'(exp_wc));

    // Backpressure: fill hold while full, stall, then drain in order
    wfull = 1'b1;
    send_beat(8'hA1, 1'b0, 1'b0);
    send_beat(8'hA2, 1'b0, 1'b0);
    send_beat(8'hA3, 1'b0, 1'b0);
    check("bp_lanes3", 32'(lanes), 32'd3);
    send_beat(8'hA4, 1'b0, 1'b0);
    repeat (3) begin
      @(negedge wclk);
      check("bp_ready", 32'(in_ready), 32'd0);
      check("bp_winc", 32'(winc), 32'd0);
      check("bp_hold", wdata, 32'hA4A3A2A1);
    end
    @(posedge wclk); #1;
    fork
      begin idle(3); wfull = 1'b0; end
      send_beat(8'hB1, 1'b0, 1'b0);
    join
    send_beat(8'hB2, 1'b0, 1'b0);
    send_beat(8'hB3, 1'b0, 1'b0);
    send_beat(8'hB4, 1'b0, 1'b0);
    idle(3);
    check("bp_count", 32'(word_count), 32'(exp_wc));

    // Reset mid-word discards the partial word and restarts the count
    send_beat(8'hC1, 1'b0, 1'b0);
    send_beat(8'hC2, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_winc", 32'(winc), 32'd0);
    check("mid_rst_wdata", wdata, 32'd0);
    check("mid_rst_lanes", 32'(lanes), 32'd0);
    check("mid_rst_count", 32'(word_count), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    mdl_word = '0; mdl_lane = 0; exp_wc = '0; sb.delete();
    @(posedge wclk); #1 rst_n = 1'b1;
    idle(2);
    check("post_rst_winc", 32'(winc), 32'd0);
    send_beat(8'hD1, 1'b0, 1'b0);
    send_beat(8'hD2, 1'b0, 1'b0);
    send_beat(8'hD3, 1'b0, 1'b0);
    send_beat(8'hD4, 1'b0, 1'b0);
    idle(3);
    check("post_rst_count", 32'(word_count), 32'd1);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
